// File: rtl/mdr_mem_port.sv
// Memory Data Register with a req/ack memory handshake engine: bus loads, sized
// memory reads with sign/zero extension, lane-replicated writes and an access timeout.
module mdr_mem_port #(
  parameter int DATA_WIDTH = 32,
  parameter int LANE_BITS  = $clog2(DATA_WIDTH/8),
  parameter int TIMEOUT    = 16
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    MDRin,
  input  logic                    Read,
  input  logic                    Write,
  input  logic [1:0]              size,
  input  logic                    sign_ext,
  input  logic [LANE_BITS-1:0]    addr_lo,
  input  logic [DATA_WIDTH-1:0]   BusMuxOut,
  input  logic [DATA_WIDTH-1:0]   Mdatain,
  input  logic                    mem_ack,
  output logic [DATA_WIDTH-1:0]   BusMuxIn,
  output logic [DATA_WIDTH-1:0]   Mdataout,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  function automatic logic is_aligned(input logic [1:0] sz, input logic [LANE_BITS-1:0] lane);
    logic ok;
    case (sz)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = (lane[0] == 1'b0);
      SZ_WORD: ok = (lane[1:0] == 2'b00);
      default: ok = (lane == '0);
    endcase
    return ok;
  endfunction

  function automatic logic [NB-1:0] byte_enables(input logic [1:0] sz, input logic [LANE_BITS-1:0] lane);
    logic [NB-1:0] be;
    case (sz)
      SZ_BYTE: be = NB'(1'b1) << lane;
      SZ_HALF: be = NB'(2'b11) << lane;
      SZ_WORD: be = NB'(4'hF) << lane;
      default: be = '1;
    endcase
    return be;
  endfunction

  // Pull the addressed lane down to bit 0, then zero- or sign-fill above it.
  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] data,
                                                        input logic [1:0] sz,
                                                        input logic [LANE_BITS-1:0] lane,
                                                        input logic sext);
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] res;
    int w;
    sh = data >> {lane, 3'b000};
    case (sz)
      SZ_BYTE: w = 8;
      SZ_HALF: w = 16;
      SZ_WORD: w = 32;
      default: w = DATA_WIDTH;
    endcase
    mask = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - w);
    res  = sh & mask;
    if (sext && sh[w-1]) begin
      res = res | ~mask;
    end else begin
      res = res;
    end
    return res;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] replicate(input logic [DATA_WIDTH-1:0] mdr, input logic [1:0] sz);
    logic [DATA_WIDTH-1:0] res;
    int k;
    case (sz)
      SZ_BYTE: k = 1;
      SZ_HALF: k = 2;
      SZ_WORD: k = 4;
      default: k = NB;
    endcase
    for (int i = 0; i < NB; i++) begin
      res[i*8 +: 8] = mdr[(i % k)*8 +: 8];
    end
    return res;
  endfunction

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [NB-1:0]         be_q, be_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            size_q, size_d;
  logic [LANE_BITS-1:0]  lane_q, lane_d;
  logic                  sext_q, sext_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  timed_out_s;

  assign timed_out_s = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

  // Next-state: command decode in IDLE, ack/timeout handling while an access is open.
  always_comb begin
    state_d = state_q;
    mdr_d   = mdr_q;
    dout_d  = dout_q;
    be_d    = be_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    lane_d  = lane_q;
    sext_d  = sext_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Read || Write) begin
          if (is_aligned(size, addr_lo)) begin
            state_d = Read ? S_RD : S_WR;
            be_d    = byte_enables(size, addr_lo);
            cnt_d   = '0;
            size_d  = size;
            lane_d  = addr_lo;
            sext_d  = sign_ext;
            if (!Read) begin
              dout_d = replicate(mdr_q, size);
            end else begin
              dout_d = dout_q;
            end
          end else begin
            err_d = 1'b1;
          end
        end else if (MDRin) begin
          mdr_d = BusMuxOut;
        end else begin
          mdr_d = mdr_q;
        end
      end
      S_RD, S_WR: begin
        if (mem_ack) begin
          if (state_q == S_RD) begin
            mdr_d = load_extend(Mdatain, size_q, lane_q, sext_q);
          end else begin
            mdr_d = mdr_q;
          end
          state_d = S_IDLE;
          be_d    = '0;
          done_d  = 1'b1;
        end else if (timed_out_s) begin
          state_d = S_IDLE;
          be_d    = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        be_d    = '0;
      end
    endcase
  end

  // State and datapath registers; clear wins over everything.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      mdr_q   <= '0;
      dout_q  <= '0;
      be_q    <= '0;
      cnt_q   <= '0;
      size_q  <= 2'b00;
      lane_q  <= '0;
      sext_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mdr_q   <= mdr_d;
      dout_q  <= dout_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
      sext_q  <= sext_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign BusMuxIn = mdr_q;
  assign Mdataout = dout_q;
  assign mem_be   = be_q;
  assign mem_rd   = (state_q == S_RD);
  assign mem_wr   = (state_q == S_WR);
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mdr_mem_port.sv
// Directed bench for mdr_mem_port: vector table of loads/reads/writes plus
// hand-written sequences for reset, priority, busy-ignore and timeout.
module tb_mdr_mem_port;

  localparam int OP_LOAD = 0;
  localparam int OP_RD   = 1;
  localparam int OP_WR   = 2;

  logic        clock = 1'b0;
  logic        clear;
  logic        MDRin, Read, Write, sign_ext, mem_ack;
  logic [1:0]  size;
  logic [1:0]  addr_lo;
  logic [31:0] BusMuxOut, Mdatain;
  logic [31:0] BusMuxIn, Mdataout;
  logic [3:0]  mem_be;
  logic        mem_rd, mem_wr, busy, done, err;

  int errors = 0;
  int checks = 0;

  mdr_mem_port #(.DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .clock(clock), .clear(clear), .MDRin(MDRin), .Read(Read), .Write(Write),
    .size(size), .sign_ext(sign_ext), .addr_lo(addr_lo), .BusMuxOut(BusMuxOut),
    .Mdatain(Mdatain), .mem_ack(mem_ack), .BusMuxIn(BusMuxIn), .Mdataout(Mdataout),
    .mem_be(mem_be), .mem_rd(mem_rd), .mem_wr(mem_wr), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          op;
    logic [1:0]  size;
    logic        sext;
    logic [1:0]  addr;
    logic [31:0] bus;
    logic [31:0] mdin;
    int          waits;
    logic [3:0]  exp_be;
    logic [31:0] exp_out;
    logic [31:0] exp_bus;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    size = v.size; sign_ext = v.sext; addr_lo = v.addr; BusMuxOut = v.bus;
    if (v.op == OP_LOAD) MDRin = 1'b1;
    else if (v.op == OP_RD) Read = 1'b1;
    else Write = 1'b1;
    step();
    MDRin = 1'b0; Read = 1'b0; Write = 1'b0;
    if (v.op == OP_LOAD) begin
      chk({tag, " load bus"}, BusMuxIn, v.exp_bus);
      chk({tag, " load done"}, done, 1'b0);
      chk({tag, " load busy"}, busy, 1'b0);
    end else if (v.exp_err) begin
      chk({tag, " misalign err"}, err, 1'b1);
      chk({tag, " misalign busy"}, busy, 1'b0);
      chk({tag, " misalign req"}, {mem_rd, mem_wr}, 2'b00);
      chk({tag, " misalign bus"}, BusMuxIn, v.exp_bus);
      step();
      chk({tag, " err pulse end"}, err, 1'b0);
    end else begin
      chk({tag, " busy"}, busy, 1'b1);
      chk({tag, " mem_rd"}, mem_rd, (v.op == OP_RD));
      chk({tag, " mem_wr"}, mem_wr, (v.op == OP_WR));
      chk({tag, " mem_be"}, mem_be, v.exp_be);
      if (v.op == OP_WR) chk({tag, " Mdataout"}, Mdataout, v.exp_out);
      Mdatain = 32'hA5A5_A5A5;
      for (int w = 0; w < v.waits; w++) begin
        step();
        chk({tag, " wait busy"}, busy, 1'b1);
        chk({tag, " wait done"}, done, 1'b0);
      end
      mem_ack = 1'b1; Mdatain = v.mdin;
      step();
      mem_ack = 1'b0; Mdatain = 32'h0;
      chk({tag, " done"}, done, 1'b1);
      chk({tag, " no err"}, err, 1'b0);
      chk({tag, " idle"}, busy, 1'b0);
      chk({tag, " result"}, BusMuxIn, v.exp_bus);
      step();
      chk({tag, " done pulse end"}, done, 1'b0);
    end
  endtask

  initial begin
    int ndone;
    vecs[0]  = '{OP_LOAD, 2'b00, 1'b0, 2'd0, 32'hDEAD_BEEF, 32'h0,         0, 4'b0000, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[1]  = '{OP_RD,   2'b00, 1'b1, 2'd2, 32'h0,         32'h0080_0000, 3, 4'b0100, 32'h0,         32'hFFFF_FF80, 1'b0};
    vecs[2]  = '{OP_RD,   2'b00, 1'b0, 2'd2, 32'h0,         32'h0080_0000, 0, 4'b0100, 32'h0,         32'h0000_0080, 1'b0};
    vecs[3]  = '{OP_RD,   2'b01, 1'b1, 2'd2, 32'h0,         32'h8001_1234, 1, 4'b1100, 32'h0,         32'hFFFF_8001, 1'b0};
    vecs[4]  = '{OP_RD,   2'b01, 1'b0, 2'd0, 32'h0,         32'h8001_F234, 0, 4'b0011, 32'h0,         32'h0000_F234, 1'b0};
    vecs[5]  = '{OP_RD,   2'b10, 1'b1, 2'd0, 32'h0,         32'hCAFE_F00D, 2, 4'b1111, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[6]  = '{OP_RD,   2'b00, 1'b1, 2'd3, 32'h0,         32'h7F00_0000, 0, 4'b1000, 32'h0,         32'h0000_007F, 1'b0};
    vecs[7]  = '{OP_LOAD, 2'b00, 1'b0, 2'd0, 32'h1234_ABCD, 32'h0,         0, 4'b0000, 32'h0,         32'h1234_ABCD, 1'b0};
    vecs[8]  = '{OP_WR,   2'b01, 1'b0, 2'd2, 32'h0,         32'h0,         2, 4'b1100, 32'hABCD_ABCD, 32'h1234_ABCD, 1'b0};
    vecs[9]  = '{OP_WR,   2'b00, 1'b0, 2'd1, 32'h0,         32'h0,         0, 4'b0010, 32'hCDCD_CDCD, 32'h1234_ABCD, 1'b0};
    vecs[10] = '{OP_WR,   2'b10, 1'b0, 2'd0, 32'h0,         32'h0,         1, 4'b1111, 32'h1234_ABCD, 32'h1234_ABCD, 1'b0};
    vecs[11] = '{OP_RD,   2'b10, 1'b0, 2'd1, 32'h0,         32'h0,         0, 4'b0000, 32'h0,         32'h1234_ABCD, 1'b1};
    vecs[12] = '{OP_WR,   2'b01, 1'b0, 2'd1, 32'h0,         32'h0,         0, 4'b0000, 32'h0,         32'h1234_ABCD, 1'b1};
    vecs[13] = '{OP_RD,   2'b11, 1'b1, 2'd0, 32'h0,         32'h5555_AAAA, 0, 4'b1111, 32'h0,         32'h5555_AAAA, 1'b0};

    clear = 1'b1; MDRin = 1'b0; Read = 1'b0; Write = 1'b0; sign_ext = 1'b0; mem_ack = 1'b0;
    size = 2'b00; addr_lo = 2'd0; BusMuxOut = 32'h0; Mdatain = 32'h0;
    #12;
    chk("reset BusMuxIn", BusMuxIn, 32'h0);
    chk("reset outs", {busy, mem_rd, mem_wr, done, err, mem_be}, 9'h0);
    chk("reset Mdataout", Mdataout, 32'h0);
    clear = 1'b0;
    step();

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Read + Write + MDRin together: read wins, MDRin ignored.
    Read = 1'b1; Write = 1'b1; MDRin = 1'b1; size = 2'b10; addr_lo = 2'd0; BusMuxOut = 32'h1111_1111;
    step();
    Read = 1'b0; Write = 1'b0; MDRin = 1'b0;
    chk("prio rd/wr", {mem_rd, mem_wr}, 2'b10);
    chk("prio mdr kept", BusMuxIn, 32'h5555_AAAA);
    // Second Read while busy must be ignored.
    Read = 1'b1; size = 2'b00; addr_lo = 2'd3; sign_ext = 1'b1;
    step();
    Read = 1'b0;
    chk("busy ignore be", mem_be, 4'b1111);
    mem_ack = 1'b1; Mdatain = 32'h2222_2222;
    step();
    mem_ack = 1'b0;
    chk("prio result", BusMuxIn, 32'h2222_2222);
    ndone = int'(done);
    for (int c = 0; c < 3; c++) begin
      step();
      ndone += int'(done);
      chk("stay idle", busy, 1'b0);
    end
    chk("single done", ndone, 1);

    // Timeout with no ack: err after 4 RD cycles, MDR unchanged.
    Read = 1'b1; size = 2'b10; addr_lo = 2'd0;
    step();
    Read = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("to pending busy", busy, 1'b1);
      chk("to pending err", err, 1'b0);
      step();
    end
    chk("to still rd", mem_rd, 1'b1);
    step();
    chk("to err", err, 1'b1);
    chk("to done", done, 1'b0);
    chk("to idle", {busy, mem_rd}, 2'b00);
    chk("to mdr kept", BusMuxIn, 32'h2222_2222);
    step();
    chk("to err end", err, 1'b0);

    // Async clear mid-access.
    Read = 1'b1; size = 2'b10; addr_lo = 2'd0;
    step();
    Read = 1'b0;
    #2;
    clear = 1'b1;
    #1;
    chk("clr BusMuxIn", BusMuxIn, 32'h0);
    chk("clr busy/rd/wr", {busy, mem_rd, mem_wr}, 3'b000);
    #3;
    clear = 1'b0;
    mem_ack = 1'b1; Mdatain = 32'h9999_9999;
    step();
    mem_ack = 1'b0;
    chk("clr no done/err", {done, err}, 2'b00);
    chk("clr mdr stays 0", BusMuxIn, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
